// File: rtl/sentinel_mont_mul_pipe.sv
// Radix-2 Montgomery multiplier: result = A*B*2^-WIDTH mod M, one bit of A per cycle.
// Define SENTINEL_MONT_FINAL_SUB_EN to add the final conditional subtraction (REDUCE state).
module sentinel_mont_mul_pipe #(
  parameter int WIDTH = 256,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [WIDTH-1:0] modulus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err_even_mod,
  output logic             busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready depends only on state; out_valid/result/err_even_mod hold until out_ready.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_REDUCE  = 2'd2,
    S_OUT     = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH+1:0] t_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic             xfer;
  logic             last_iter;
  logic [WIDTH+1:0] t_add;
  logic [WIDTH+1:0] t_odd;
  logic [WIDTH+1:0] t_step;

  assign xfer      = in_valid && in_ready;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // T stays below 2M, so T + B + M < 4M fits in WIDTH+2 bits before the halving.
  always_comb begin
    t_add  = t_q + (a_q[0] ? {2'b00, b_q} : '0);
    t_odd  = t_add[0] ? (t_add + {2'b00, m_q}) : t_add;
    t_step = t_odd >> 1;
  end

`ifdef SENTINEL_MONT_FINAL_SUB_EN
  logic [WIDTH+1:0] t_sub;
  logic [WIDTH-1:0] t_red;

  always_comb begin
    t_sub = t_q - {2'b00, m_q};
    t_red = (t_q >= {2'b00, m_q}) ? t_sub[WIDTH-1:0] : t_q[WIDTH-1:0];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_nxt = modulus[0] ? S_COMPUTE : S_OUT;
        end
      end
      S_COMPUTE: begin
        if (last_iter) begin
`ifdef SENTINEL_MONT_FINAL_SUB_EN
          state_nxt = S_REDUCE;
`else
          state_nxt = S_OUT;
`endif
        end
      end
      S_REDUCE: begin
        state_nxt = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Operands are captured only on a transfer, so input changes while busy are invisible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      t_q      <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (xfer) begin
            a_q      <= operand_a;
            b_q      <= operand_b;
            m_q      <= modulus;
            t_q      <= '0;
            cnt_q    <= '0;
            err_q    <= ~modulus[0];
            result_q <= '0;
          end
        end
        S_COMPUTE: begin
          t_q   <= t_step;
          a_q   <= a_q >> 1;
          cnt_q <= cnt_q + CNT_W'(1);
`ifndef SENTINEL_MONT_FINAL_SUB_EN
          if (last_iter) begin
            result_q <= t_step[WIDTH-1:0];
          end
`endif
        end
        S_REDUCE: begin
`ifdef SENTINEL_MONT_FINAL_SUB_EN
          result_q <= t_red;
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign result       = result_q;
  assign err_even_mod = err_q;

endmodule

// File: tb/tb_sentinel_mont_mul_pipe.sv
// Bench for sentinel_mont_mul_pipe: an 8-bit instance for directed cases and a 256-bit
// instance for random operands, both checked against a division-based Montgomery reference.
module tb_sentinel_mont_mul_pipe;
  localparam int W   = 8;
  localparam int WB  = 256;
  localparam int TMO = 2000;
`ifdef SENTINEL_MONT_FINAL_SUB_EN
  localparam int LAT   = W + 2;
  localparam int LAT_B = WB + 2;
`else
  localparam int LAT   = W + 1;
  localparam int LAT_B = WB + 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  // ---------------- 8-bit instance ----------------
  logic         in_valid, in_ready, out_valid, out_ready, err_even_mod, busy;
  logic [W-1:0] operand_a, operand_b, modulus, result;

  sentinel_mont_mul_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .operand_a(operand_a), .operand_b(operand_b), .modulus(modulus),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err_even_mod(err_even_mod), .busy(busy)
  );

  // ---------------- 256-bit instance ----------------
  logic          w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_err_even_mod, w_busy;
  logic [WB-1:0] w_operand_a, w_operand_b, w_modulus, w_result;

  sentinel_mont_mul_pipe #(.WIDTH(WB)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .operand_a(w_operand_a), .operand_b(w_operand_b), .modulus(w_modulus),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .result(w_result), .err_even_mod(w_err_even_mod), .busy(w_busy)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  mod_q[$];
  logic          err_exp_q[$];
  logic [WB-1:0] w_exp_q[$];
  logic [WB-1:0] w_mod_q[$];
  int            xfer_edge, w_xfer_edge;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [WB:0] got, input logic [WB:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // A*B*2^-w mod m via the modular inverse of 2, using plain division.
  function automatic logic [WB-1:0] mont_ref(input logic [WB-1:0] a, b, m, input int w);
    logic [2*WB-1:0] mm, p, inv2, rinv;
    mm   = {{WB{1'b0}}, m};
    p    = ({{WB{1'b0}}, a} * {{WB{1'b0}}, b}) % mm;
    inv2 = (mm + 1) >> 1;
    rinv = 1;
    for (int i = 0; i < w; i++) rinv = (rinv * inv2) % mm;
    p = (p * rinv) % mm;
    return p[WB-1:0];
  endfunction

  function automatic logic [WB-1:0] norm(input logic [WB-1:0] r, m);
    return (r >= m) ? r - m : r;
  endfunction

  function automatic logic [WB-1:0] rand_wide();
    logic [WB-1:0] v;
    for (int k = 0; k < WB / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- 8-bit driver tasks ----------------
  task automatic send8(input logic [W-1:0] a, b, m);
    int            waited = 0;
    logic [WB-1:0] r;
    while (!in_ready && waited < TMO) begin
      @(posedge clk); #1; waited++;
    end
    check("in_ready_wait", in_ready, 1'b1);
    in_valid = 1'b1; operand_a = a; operand_b = b; modulus = m;
    @(posedge clk); #1;
    xfer_edge = edge_cnt;
    in_valid  = 1'b0;
    operand_a = W'($urandom); operand_b = W'($urandom); modulus = W'($urandom);
    r = m[0] ? mont_ref({{(WB-W){1'b0}}, a}, {{(WB-W){1'b0}}, b}, {{(WB-W){1'b0}}, m}, W) : '0;
    exp_q.push_back(r[W-1:0]);
    mod_q.push_back(m);
    err_exp_q.push_back(~m[0]);
  endtask

  // Waits for out_valid, checks latency and pops/compares one expected result.
  task automatic collect8(input int exp_lat, output logic [W-1:0] e, output logic [W-1:0] m);
    int   waited = 0;
    logic ee;
    e = '0; m = 8'd1;
    while (!out_valid && waited < TMO) begin
      @(posedge clk); #1; waited++;
    end
    check("out_valid_wait", out_valid, 1'b1);
    check("latency", edge_cnt - xfer_edge + 1, exp_lat);
    check("exp_q_nonempty", exp_q.size() > 0, 1'b1);
    if (exp_q.size() == 0) return;
    e  = exp_q.pop_front();
    m  = mod_q.pop_front();
    ee = err_exp_q.pop_front();
    check("err_even_mod", err_even_mod, ee);
`ifdef SENTINEL_MONT_FINAL_SUB_EN
    check("result", result, e);
`else
    check("result_lt_2m", {1'b0, result} < {m, 1'b0}, 1'b1);
    check("result_mod", norm({{(WB-W){1'b0}}, result}, {{(WB-W){1'b0}}, m}), e);
`endif
  endtask

  task automatic finish8();
    @(posedge clk); #1;
    check("idle_out_valid", out_valid, 1'b0);
    check("idle_in_ready", in_ready, 1'b1);
  endtask

  // ---------------- 256-bit driver tasks ----------------
  task automatic send_w(input logic [WB-1:0] a, b, m);
    int waited = 0;
    while (!w_in_ready && waited < TMO) begin
      @(posedge clk); #1; waited++;
    end
    check("w_in_ready_wait", w_in_ready, 1'b1);
    w_in_valid = 1'b1; w_operand_a = a; w_operand_b = b; w_modulus = m;
    @(posedge clk); #1;
    w_xfer_edge = edge_cnt;
    w_in_valid  = 1'b0;
    w_operand_a = rand_wide(); w_operand_b = rand_wide(); w_modulus = rand_wide();
    w_exp_q.push_back(mont_ref(a, b, m, WB));
    w_mod_q.push_back(m);
  endtask

  task automatic collect_w();
    int            waited = 0;
    logic [WB-1:0] e, m;
    while (!w_out_valid && waited < TMO) begin
      @(posedge clk); #1; waited++;
    end
    check("w_out_valid_wait", w_out_valid, 1'b1);
    check("w_latency", edge_cnt - w_xfer_edge + 1, LAT_B);
    check("w_exp_q_nonempty", w_exp_q.size() > 0, 1'b1);
    if (w_exp_q.size() == 0) return;
    e = w_exp_q.pop_front();
    m = w_mod_q.pop_front();
    check("w_err_even_mod", w_err_even_mod, 1'b0);
`ifdef SENTINEL_MONT_FINAL_SUB_EN
    check("w_result", w_result, e);
`else
    check("w_result_lt_2m", {1'b0, w_result} < {m, 1'b0}, 1'b1);
    check("w_result_mod", norm(w_result, m), e);
`endif
    @(posedge clk); #1;
    check("w_idle_out_valid", w_out_valid, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0]  e, m, a, b;
    logic [WB-1:0] wa, wb, wm;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; operand_a = '0; operand_b = '0; modulus = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b1; w_operand_a = '0; w_operand_b = '0; w_modulus = '0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_result", result, 0);
    check("rst_err", err_even_mod, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_out_valid", out_valid, 1'b0);

    // Directed odd-modulus products.
    send8(8'd5, 8'd7, 8'd13);   collect8(LAT, e, m); check("dir_5x7", e, 1);  finish8();
    send8(8'd12, 8'd12, 8'd13); collect8(LAT, e, m); check("dir_12x12", e, 3); finish8();
    send8(8'd0, 8'd9, 8'd13);   collect8(LAT, e, m); finish8();

    // Even modulus flags an error immediately; next good transfer clears it.
    send8(8'd5, 8'd3, 8'd12);
    collect8(1, e, m);
    finish8();
    send8(8'd5, 8'd7, 8'd13);
    check("err_cleared_on_xfer", err_even_mod, 1'b0);
    check("busy_after_xfer", busy, 1'b1);
    collect8(LAT, e, m);
    finish8();

    // Back-pressure: result held for 20 cycles, inputs ignored.
    out_ready = 1'b0;
    send8(8'd5, 8'd7, 8'd13);
    collect8(LAT, e, m);
    for (int i = 0; i < 20; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      operand_a = W'($urandom); operand_b = W'($urandom); modulus = W'($urandom);
      @(posedge clk); #1;
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_result", norm({{(WB-W){1'b0}}, result}, {{(WB-W){1'b0}}, m}), e);
    end
    // Output handshake edge must not also accept the offered input.
    in_valid = 1'b1; operand_a = 8'd12; operand_b = 8'd12; modulus = 8'd13; out_ready = 1'b1;
    @(posedge clk); #1;
    check("hs_no_accept_busy", busy, 1'b0);
    check("hs_out_valid", out_valid, 1'b0);
    in_valid = 1'b0;

    // Reset during COMPUTE abandons the operation.
    send8(8'd5, 8'd7, 8'd13);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_result", result, 0);
    exp_q.delete(); mod_q.delete(); err_exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (W + 4) @(posedge clk);
    #1;
    check("no_result_after_rst", out_valid, 1'b0);
    send8(8'd12, 8'd1, 8'd13); collect8(LAT, e, m); check("dir_12x1", e, 10); finish8();

    // Random 8-bit operands with random output stalls (M < 128 leaves lazy headroom).
    for (int i = 0; i < 30; i++) begin
      m = W'($urandom_range(1, 63) * 2 + 1);
      a = W'($urandom_range(0, int'(m) - 1));
      b = W'($urandom_range(0, int'(m) - 1));
      out_ready = 1'b0;
      send8(a, b, m);
      collect8(LAT, e, m);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1 out_ready = 1'b1;
      finish8();
    end

    // Random 256-bit operands (top modulus bit clear for lazy headroom).
    for (int i = 0; i < 30; i++) begin
      wm = rand_wide();
      wm[WB-1] = 1'b0;
      wm[0]    = 1'b1;
      wa = rand_wide() % wm;
      wb = rand_wide() % wm;
      send_w(wa, wb, wm);
      collect_w();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end
endmodule
